// File: rtl/sensor_alarm_pkg.sv
// Shared types and elaboration-time helpers for the sensor alarm engine.
package sensor_alarm_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        ALARM    = 2'd2,
        SILENCED = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Counter widths never collapse to zero bits.
    function automatic int width_min1(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

    function automatic int beep_half(input int clk_hz, input int beep_hz);
        return ((clk_hz / (2 * beep_hz)) < 1) ? 1 : (clk_hz / (2 * beep_hz));
    endfunction

endpackage

// File: rtl/sensor_channel_monitor.sv
// One sensor channel: high threshold with hysteresis band, persistence count and enable mask.
module sensor_channel_monitor
    import sensor_alarm_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PERSIST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] value,
    input  logic [DATA_W-1:0] thr,
    input  logic [DATA_W-1:0] hyst,
    input  logic              enable,
    output logic              ch_alarm
);

    localparam int CW = width_min1(PERSIST + 1);

    logic [CW-1:0]     r_over_cnt;
    logic              r_alarm;
    logic [DATA_W-1:0] w_lo;

    assign w_lo = (thr > hyst) ? (thr - hyst) : '0;

    // Between lo and thr both the counter and the alarm hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_over_cnt <= '0;
            r_alarm    <= 1'b0;
        end else if (!enable) begin
            r_over_cnt <= '0;
            r_alarm    <= 1'b0;
        end else if (sample_valid) begin
            if (value >= thr) begin
                if (r_over_cnt < CW'(PERSIST)) begin
                    r_over_cnt <= r_over_cnt + 1'b1;
                end
                if (r_over_cnt >= CW'(PERSIST - 1)) begin
                    r_alarm <= 1'b1;
                end
            end else if (value <= w_lo) begin
                r_over_cnt <= '0;
                r_alarm    <= 1'b0;
            end
        end
    end

    assign ch_alarm = r_alarm;

endmodule

// File: rtl/sensor_alarm_engine.sv
// Multi-channel threshold alarm with remote warning, arm/alarm/silence FSM and beeper.
module sensor_alarm_engine
    import sensor_alarm_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter int DATA_W  = 8,
    parameter int PERSIST = 4,
    parameter int CLK_HZ  = 40_000_000,
    parameter int BEEP_HZ = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_valid,
    input  logic [NUM_CH*DATA_W-1:0] sample_data,
    input  logic [NUM_CH*DATA_W-1:0] thr_high,
    input  logic [DATA_W-1:0]        hyst,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic                     remote_warn,
    input  logic                     arm_btn,
    input  logic                     ack_btn,
    output logic                     armed,
    output logic [NUM_CH-1:0]        ch_alarm,
    output logic                     alarm_active,
    output logic [NUM_CH:0]          alarm_cause,
    output logic                     buzzer,
    output logic                     warn_led,
    output logic                     sim_trigger
);

    localparam int HALF = beep_half(CLK_HZ, BEEP_HZ);
    localparam int BW   = width_min1(HALF);

    state_t          r_state, w_next;
    logic            r_arm_prev, r_ack_prev;
    logic [NUM_CH:0] r_cause, w_cause_next;
    logic            r_sim, w_sim_next;
    logic            r_buzzer;
    logic [BW-1:0]   r_beep_cnt;
    logic            w_arm_edge, w_ack_edge;
    logic [NUM_CH:0] w_cause_now;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sensor_channel_monitor #(
            .DATA_W  (DATA_W),
            .PERSIST (PERSIST)
        ) u_mon (
            .clk          (clk),
            .rst          (rst),
            .sample_valid (sample_valid),
            .value        (sample_data[i*DATA_W +: DATA_W]),
            .thr          (thr_high[i*DATA_W +: DATA_W]),
            .hyst         (hyst),
            .enable       (ch_mask[i]),
            .ch_alarm     (ch_alarm[i])
        );
    end

    assign w_arm_edge  = arm_btn & ~r_arm_prev;
    assign w_ack_edge  = ack_btn & ~r_ack_prev;
    assign w_cause_now = {remote_warn, ch_alarm};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ARMED;
            r_arm_prev <= 1'b0;
            r_ack_prev <= 1'b0;
            r_cause    <= '0;
            r_sim      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_arm_prev <= arm_btn;
            r_ack_prev <= ack_btn;
            r_cause    <= w_cause_next;
            r_sim      <= w_sim_next;
        end
    end

    // Arm edge outranks a new cause, which outranks ack or clear.
    always_comb begin
        w_next       = r_state;
        w_cause_next = r_cause;
        w_sim_next   = 1'b0;
        unique case (r_state)
            DISARMED: begin
                w_cause_next = '0;
                if (w_arm_edge) w_next = ARMED;
            end
            ARMED: begin
                if (w_arm_edge) begin
                    w_next = DISARMED;
                end else if (w_cause_now != '0) begin
                    w_next       = ALARM;
                    w_cause_next = w_cause_now;
                    w_sim_next   = 1'b1;
                end
            end
            ALARM: begin
                if (w_arm_edge) begin
                    w_next       = DISARMED;
                    w_cause_next = '0;
                end else begin
                    w_cause_next = r_cause | w_cause_now;
                    if (w_ack_edge) w_next = SILENCED;
                end
            end
            SILENCED: begin
                if (w_arm_edge) begin
                    w_next       = DISARMED;
                    w_cause_next = '0;
                end else if ((w_cause_now & ~r_cause) != '0) begin
                    w_next       = ALARM;
                    w_cause_next = r_cause | w_cause_now;
                    w_sim_next   = 1'b1;
                end else if (w_cause_now == '0) begin
                    w_next       = ARMED;
                    w_cause_next = '0;
                end
            end
            default: w_next = ARMED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buzzer   <= 1'b0;
            r_beep_cnt <= '0;
        end else if (w_next == ALARM && r_state != ALARM) begin
            r_buzzer   <= 1'b1;
            r_beep_cnt <= '0;
        end else if (w_next == ALARM) begin
            if (r_beep_cnt == BW'(HALF - 1)) begin
                r_buzzer   <= ~r_buzzer;
                r_beep_cnt <= '0;
            end else begin
                r_beep_cnt <= r_beep_cnt + 1'b1;
            end
        end else begin
            r_buzzer   <= 1'b0;
            r_beep_cnt <= '0;
        end
    end

    assign armed        = (r_state != DISARMED);
    assign alarm_active = (r_state == ALARM);
    assign alarm_cause  = r_cause;
    assign buzzer       = r_buzzer;
    assign warn_led     = (r_state == ALARM) ? r_buzzer : (r_state == SILENCED);
    assign sim_trigger  = r_sim;

endmodule
